// File: rtl/result_forward_pipeline.sv
// EX->MEM and MEM->WB pipeline registers that drive the ALU forwarding taps, the data-memory
// strobe and the register-file write port. Load-use detection is built only with LOAD_USE_DETECT_EN.
module result_forward_pipeline #(
  parameter int unsigned WORD        = 32,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   ex_valid_i,
  input  logic [WORD-1:0]        ex_alu_result_i,
  input  logic [ADDR_WIDTH-1:0]  ex_reg_dest_i,
  input  logic                   ex_reg_write_i,
  input  logic                   ex_mem_read_i,
  input  logic                   flush_i,
  input  logic [ADDR_WIDTH-1:0]  reg_addr_1_DECODE_i,
  input  logic [ADDR_WIDTH-1:0]  reg_addr_2_DECODE_i,
  input  logic [WORD-1:0]        mem_rdata_i,
  output logic [WORD-1:0]        mem_addr_o,
  output logic                   mem_read_en_o,
  output logic [WORD-1:0]        reg_data_MEM_o,
  output logic [ADDR_WIDTH-1:0]  reg_dest_MEM_o,
  output logic                   mem_write_en_MEM_o,
  output logic [WORD-1:0]        reg_data_WB_o,
  output logic [ADDR_WIDTH-1:0]  reg_dest_WB_o,
  output logic                   mem_write_en_WB_o,
  output logic                   load_use_stall_o,
  output logic [STALL_CNT_W-1:0] stall_count_o
);

  typedef struct packed {
    logic                  valid;
    logic [WORD-1:0]       data;
    logic [ADDR_WIDTH-1:0] dest;
    logic                  wr;
    logic                  rd;
  } stage_t;

  stage_t mem_d, mem_q;
  stage_t wb_d, wb_q;
  logic   load_use_stall;

  // A bubble is an all-zero stage, so dests and data read back as 0 when nothing is in flight.
  always_comb begin
    mem_d = '0;
    if (ex_valid_i && !flush_i && !load_use_stall) begin
      mem_d.valid = 1'b1;
      mem_d.data  = ex_alu_result_i;
      mem_d.dest  = ex_reg_dest_i;
      mem_d.wr    = ex_reg_write_i;
      mem_d.rd    = ex_mem_read_i;
    end
    wb_d = mem_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign mem_addr_o         = mem_q.data;
  assign mem_read_en_o      = mem_q.valid & mem_q.rd;
  assign reg_data_MEM_o     = mem_q.data;
  assign reg_dest_MEM_o     = mem_q.dest;
  // Load data does not exist until WB, so a load in MEM is never a forwarding source.
  assign mem_write_en_MEM_o = mem_q.valid & mem_q.wr & ~mem_q.rd;
  assign reg_data_WB_o      = (wb_q.valid && wb_q.rd) ? mem_rdata_i : wb_q.data;
  assign reg_dest_WB_o      = wb_q.dest;
  assign mem_write_en_WB_o  = wb_q.valid & wb_q.wr;

`ifdef LOAD_USE_DETECT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  assign load_use_stall = mem_q.valid & mem_q.rd & mem_q.wr & ~flush_i &
                          ((mem_q.dest == reg_addr_1_DECODE_i) |
                           (mem_q.dest == reg_addr_2_DECODE_i));

  // Saturating: holds at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (load_use_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count_o = stall_cnt_q;
`else
  logic unused_decode;
  assign unused_decode  = ^{reg_addr_1_DECODE_i, reg_addr_2_DECODE_i};
  assign load_use_stall = 1'b0;
  assign stall_count_o  = '0;
`endif

  assign load_use_stall_o = load_use_stall;

endmodule
